multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; ports are named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous active-high reset, sampled on rising clk.
REQ-004 start  input  1  one-cycle request to execute one instruction; honoured only in IDLE.
REQ-005 run  input  1  level; while high, the controller chains instructions back-to-back.
REQ-006 Op  input  6  instruction bits [31:26] from the instruction register.
REQ-007 Func  input  6  instruction bits [5:0] from the instruction register.
REQ-008 PCWrite  output  1  PC register load enable.
REQ-009 IRWrite  output  1  instruction register load enable.
REQ-010 RegWrite  output  1  register file write enable (D_En).
REQ-011 ALUCntl  output  4  ALU operation select.
REQ-012 busy  output  1  high in every state except IDLE and FAULT.
REQ-013 done  output  1  one-cycle pulse in the writeback cycle.
REQ-014 fault  output  1  sticky illegal-instruction flag.
REQ-015 inst_count  output  16  count of retired instructions.

Function
REQ-016 SHALL implement the states IDLE, FETCH, DECODE, EXEC, WB and FAULT.
REQ-017 IDLE->FETCH when start=1 or run=1; otherwise the controller stays in IDLE.
REQ-018 FETCH->DECODE unconditionally; FETCH drives IRWrite=1 and PCWrite=1 for exactly this cycle.
REQ-019 DECODE samples Op and Func.
  - Legal: register ALUCntl and go to EXEC.
  - Illegal: go to FAULT; ALUCntl is unchanged.
REQ-020 Legal means Op=6'h00 and Func in the following set:
  - 0x20 or 0x21 -> 0010
  - 0x22 or 0x23 -> 0110
  - 0x24 -> 0000
  - 0x25 -> 0001
  - 0x27 -> 1100
  - 0x2A -> 0111
REQ-021 Every other Op/Func combination SHALL be illegal.
REQ-022 EXEC->WB unconditionally, with all strobes low.
REQ-023 WB asserts RegWrite=1 and done=1 for one cycle and increments inst_count.
REQ-024 WB->FETCH if run=1 in the WB cycle, else WB->IDLE.
REQ-025 PCWrite, IRWrite, RegWrite and done SHALL be Moore outputs decoded from state only.
REQ-026 ALUCntl SHALL be registered and held constant from the cycle after DECODE until the next DECODE.
REQ-027 Latency: an isolated start yields done exactly 4 cycles later (FETCH, DECODE, EXEC, WB).
REQ-028 In run mode, one instruction SHALL retire every 4 cycles.
REQ-029 start while busy SHALL be ignored, with no queuing.
REQ-030 Dropping run mid-instruction SHALL complete the current instruction, then go to IDLE.
REQ-031 inst_count SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-032 FAULT SHALL be absorbing: all strobes low, fault=1, and start/run ignored; only reset exits it.
REQ-033 No RegWrite or done SHALL occur for a faulting instruction; inst_count is not incremented.

Reset
REQ-034 Reset SHALL put the controller in IDLE with ALUCntl=0000, inst_count=0, fault=0 and all strobes 0.
REQ-035 Reset SHALL take priority over all transitions, including mid-instruction and in FAULT.
REQ-036 Reset asserted in WB SHALL suppress the count increment.

Structure
REQ-037 A shared package SHALL hold:
  - the state enum;
  - ALUCntl constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR);
  - the Op/Func code constants.
REQ-038 A combinational sub-module alu_decoder (Op, Func -> ALUCntl, legal) SHALL be instantiated once; the FSM and counter live in multicycle_control.

Verification
REQ-039 Reset, then start pulse with Op=00, Func=0x20 -> IRWrite and PCWrite in cycle 1, done and RegWrite in cycle 4, ALUCntl=0010, inst_count=1.
REQ-040 run held high for 12 cycles with Func=0x22 -> 3 done pulses 4 cycles apart, ALUCntl=0110, inst_count=3.
REQ-041 start with Op=0x23 -> FAULT after DECODE, fault=1, RegWrite never set, inst_count unchanged; a later start is ignored until reset.
REQ-042 Second start pulsed during EXEC -> ignored, exactly one done.
REQ-043 Preload inst_count to 0xFFFF via 65535 run-mode instructions, then one more -> inst_count=0x0000.
REQ-044 Reset asserted during EXEC -> IDLE next cycle, ALUCntl=0000, no done, busy=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// multicycle_control_pkg
// Shared state encoding, ALU select codes and instruction field codes.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_control_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//------------------------------------------------------------------------------
// alu_decoder
// Combinational Op/Func decode to ALU select plus a legality flag.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_decoder
   import multicycle_control_pkg::*;
(
   input  logic [5:0] Op,
   input  logic [5:0] Func,
   output logic [3:0] ALUCntl,
   output logic       legal
);

   always_comb begin
      ALUCntl = ALU_AND;
      legal   = 1'b0;
      if (Op == OP_RTYPE) begin
         case (Func)
            FN_ADD, FN_ADDU: begin ALUCntl = ALU_ADD; legal = 1'b1; end
            FN_SUB, FN_SUBU: begin ALUCntl = ALU_SUB; legal = 1'b1; end
            FN_AND:          begin ALUCntl = ALU_AND; legal = 1'b1; end
            FN_OR:           begin ALUCntl = ALU_OR;  legal = 1'b1; end
            FN_NOR:          begin ALUCntl = ALU_NOR; legal = 1'b1; end
            FN_SLT:          begin ALUCntl = ALU_SLT; legal = 1'b1; end
            default:         begin ALUCntl = ALU_AND; legal = 1'b0; end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// multicycle_control
// Four-cycle fetch/decode/exec/writeback controller with sticky fault.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        run,
   input  logic [5:0]  Op,
   input  logic [5:0]  Func,
   output logic        PCWrite,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic [3:0]  ALUCntl,
   output logic        busy,
   output logic        done,
   output logic        fault,
   output logic [15:0] inst_count
);

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  w_dec_alu;
   logic        w_dec_legal;
   logic [3:0]  r_alucntl;
   logic [15:0] r_inst_count;

   alu_decoder u_alu_decoder (
      .Op      (Op),
      .Func    (Func),
      .ALUCntl (w_dec_alu),
      .legal   (w_dec_legal)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // ALU select only changes on a legal decode; the counter only moves in WB
   always_ff @(posedge clk) begin
      if (reset) begin
         r_alucntl    <= ALU_AND;
         r_inst_count <= 16'd0;
      end else begin
         if (r_state == S_DECODE && w_dec_legal) r_alucntl <= w_dec_alu;
         if (r_state == S_WB) r_inst_count <= r_inst_count + 16'd1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start || run) w_next = S_FETCH;
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = w_dec_legal ? S_EXEC : S_FAULT;
         S_EXEC:   w_next = S_WB;
         S_WB:     w_next = run ? S_FETCH : S_IDLE;
         S_FAULT:  w_next = S_FAULT;
         default:  w_next = S_IDLE;
      endcase
   end

   assign PCWrite    = (r_state == S_FETCH);
   assign IRWrite    = (r_state == S_FETCH);
   assign RegWrite   = (r_state == S_WB);
   assign done       = (r_state == S_WB);
   assign fault      = (r_state == S_FAULT);
   assign busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
   assign ALUCntl    = r_alucntl;
   assign inst_count = r_inst_count;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//------------------------------------------------------------------------------
// tb_multicycle_control
// Directed bench with a cycle-position reference model and literal checks.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        reset, start, run;
   logic [5:0]  Op, Func;
   logic        PCWrite, IRWrite, RegWrite, busy, done, fault;
   logic [3:0]  ALUCntl;
   logic [15:0] inst_count;

   multicycle_control dut (
      .clk(clk), .reset(reset), .start(start), .run(run), .Op(Op), .Func(Func),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUCntl(ALUCntl),
      .busy(busy), .done(done), .fault(fault), .inst_count(inst_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done = 0;
   int last_done_cyc = 0;
   int done_gap = 0;
   int last_fetch_cyc = 0;
   logic armed = 1'b0;
   logic preload = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: instruction timeline as position 1..4 within the current instruction
   function automatic logic [4:0] ref_decode(input logic [5:0] op, input logic [5:0] f);
      if (op != 6'h00) return 5'b0_0000;
      case (f)
         6'h20, 6'h21: return 5'b1_0010;
         6'h22, 6'h23: return 5'b1_0110;
         6'h24:        return 5'b1_0000;
         6'h25:        return 5'b1_0001;
         6'h27:        return 5'b1_1100;
         6'h2A:        return 5'b1_0111;
         default:      return 5'b0_0000;
      endcase
   endfunction

   logic        m_active = 1'b0;
   int          m_pos = 0;
   logic        m_fault = 1'b0;
   logic [3:0]  m_alu = 4'h0;
   logic [15:0] m_count = 16'h0;
   logic [4:0]  m_dec;
   assign m_dec = ref_decode(Op, Func);

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_active <= 1'b0;
         m_pos    <= 0;
         m_fault  <= 1'b0;
         m_alu    <= 4'h0;
         m_count  <= 16'h0;
         armed    <= 1'b1;
      end else begin
         if (preload) m_count <= 16'hFFFE;
         if (m_fault) begin
            m_active <= 1'b0;
         end else if (!m_active) begin
            if (start || run) begin
               m_active <= 1'b1;
               m_pos    <= 1;
            end
         end else if (m_pos == 1) begin
            m_pos <= 2;
         end else if (m_pos == 2) begin
            if (m_dec[4]) begin
               m_alu <= m_dec[3:0];
               m_pos <= 3;
            end else begin
               m_active <= 1'b0;
               m_fault  <= 1'b1;
            end
         end else if (m_pos == 3) begin
            m_pos <= 4;
         end else begin
            m_count <= m_count + 16'd1;
            if (run) m_pos <= 1;
            else     m_active <= 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (armed) begin
         chk("PCWrite",  PCWrite,  int'(m_active && m_pos == 1));
         chk("IRWrite",  IRWrite,  int'(m_active && m_pos == 1));
         chk("RegWrite", RegWrite, int'(m_active && m_pos == 4));
         chk("done",     done,     int'(m_active && m_pos == 4));
         chk("busy",     busy,     int'(m_active));
         chk("fault",    fault,    int'(m_fault));
         chk("ALUCntl",  ALUCntl,  int'(m_alu));
         if (!preload) chk("inst_count", inst_count, int'(m_count));
      end
      if (done) begin
         n_done++;
         done_gap = cyc - last_done_cyc;
         last_done_cyc = cyc;
      end
      if (PCWrite) last_fetch_cyc = cyc;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1);
      reset = 1'b0;
   endtask

   logic [5:0] fn_tab  [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27, 6'h2A};
   logic [3:0] alu_tab [8] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

   initial begin
      int d0, t0;
      reset = 1'b1; start = 1'b0; run = 1'b0; Op = 6'h00; Func = 6'h00;
      step(2);
      reset = 1'b0;
      chk("rst_alu",   ALUCntl, 0);
      chk("rst_count", inst_count, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_fault", fault, 0);

      // isolated add
      d0 = n_done; t0 = cyc;
      Func = 6'h20; start = 1'b1;
      step(1); start = 1'b0;
      step(5);
      chk("t1_fetch_lat", last_fetch_cyc - t0, 1);
      chk("t1_done_lat",  last_done_cyc - t0, 4);
      chk("t1_dones",     n_done - d0, 1);
      chk("t1_alu",       ALUCntl, 4'b0010);
      chk("t1_count",     inst_count, 1);

      // run mode for 12 cycles
      do_reset();
      d0 = n_done;
      Func = 6'h22; run = 1'b1;
      step(12); run = 1'b0;
      step(6);
      chk("t2_dones", n_done - d0, 3);
      chk("t2_gap",   done_gap, 4);
      chk("t2_alu",   ALUCntl, 4'b0110);
      chk("t2_count", inst_count, 3);

      // run dropped during the second instruction
      d0 = n_done;
      run = 1'b1;
      step(6); run = 1'b0;
      step(8);
      chk("t2b_dones", n_done - d0, 2);
      chk("t2b_count", inst_count, 5);

      // every legal function code
      for (int i = 0; i < 8; i++) begin
         d0 = n_done;
         Func = fn_tab[i]; start = 1'b1;
         step(1); start = 1'b0;
         step(5);
         chk("tab_alu",   ALUCntl, alu_tab[i]);
         chk("tab_dones", n_done - d0, 1);
      end
      chk("tab_count", inst_count, 13);

      // second start during EXEC is dropped
      d0 = n_done;
      Func = 6'h25; start = 1'b1;
      step(1); start = 1'b0;
      step(2);
      start = 1'b1;
      step(1); start = 1'b0;
      step(6);
      chk("t4_dones", n_done - d0, 1);
      chk("t4_count", inst_count, 14);
      chk("t4_alu",   ALUCntl, 4'b0001);

      // counter wrap from a preloaded near-full value
      dut.r_inst_count = 16'hFFFE;
      preload = 1'b1;
      step(1); preload = 1'b0;
      d0 = n_done;
      Func = 6'h2A; run = 1'b1;
      step(8); run = 1'b0;
      step(4);
      chk("t5_dones", n_done - d0, 2);
      chk("t5_count", inst_count, 0);
      chk("t5_alu",   ALUCntl, 4'b0111);

      // reset while in EXEC
      d0 = n_done;
      Func = 6'h20; start = 1'b1;
      step(1); start = 1'b0;
      step(2);
      reset = 1'b1;
      step(1); reset = 1'b0;
      chk("t6_busy",  busy, 0);
      chk("t6_alu",   ALUCntl, 0);
      chk("t6_count", inst_count, 0);
      step(4);
      chk("t6_dones", n_done - d0, 0);

      // illegal opcode parks the controller in FAULT
      d0 = n_done;
      Op = 6'h23; Func = 6'h20; start = 1'b1;
      step(1); start = 1'b0;
      step(4);
      chk("t7_fault", fault, 1);
      chk("t7_busy",  busy, 0);
      chk("t7_count", inst_count, 0);
      chk("t7_alu",   ALUCntl, 0);
      Op = 6'h00; start = 1'b1;
      step(1); start = 1'b0; run = 1'b1;
      step(6); run = 1'b0;
      chk("t7_sticky", fault, 1);
      chk("t7_dones",  n_done - d0, 0);
      do_reset();
      chk("t7_cleared", fault, 0);

      // illegal function with the R-type opcode
      Func = 6'h26; start = 1'b1;
      step(1); start = 1'b0;
      step(4);
      chk("t8_fault", fault, 1);
      chk("t8_dones", n_done - d0, 0);
      do_reset();
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
